// File: rtl/max_pool_2x2_if.sv
// Stream interface for max_pool_2x2: pixel input channel and pooled output channel.
// master = upstream/downstream side, slave = the pooling block.
interface max_pool_2x2_if #(
  parameter int WORD_SIZE = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_pixel;
  logic                 out_eol;
  logic                 out_eof;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_eol, out_eof
  );
endinterface

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max pooling with a half-row line buffer of partial maxima.
// Optional MAXPOOL_BINARIZE_EN: pooled value becomes all-ones if >= THRESHOLD, else 0.
module max_pool_2x2 #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540,
  parameter int COL_SIZE  = 540,
  parameter int THRESHOLD = 64
) (
  input  logic           clk,
  input  logic           rst,
  max_pool_2x2_if.slave  bus
);
  localparam int COL_W    = $clog2(ROW_SIZE);
  localparam int ROW_W    = $clog2(COL_SIZE);
  localparam int LB_DEPTH = ROW_SIZE / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0]     COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(COL_SIZE - 1);
  localparam logic [WORD_SIZE-1:0] THRESH_W = WORD_SIZE'(THRESHOLD);

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [WORD_SIZE-1:0] pmax_q, pmax_d;
  logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_eol_q, out_eol_d;
  logic                 out_eof_q, out_eof_d;

  logic [WORD_SIZE-1:0] line_buf [LB_DEPTH];

  logic                 in_ready;
  logic                 accept;
  logic                 transfer;
  logic                 col_last;
  logic                 row_last;
  logic                 lb_we;
  logic [LB_AW-1:0]     lb_idx;
  logic [WORD_SIZE-1:0] lb_rd;
  logic [WORD_SIZE-1:0] pair_max;
  logic [WORD_SIZE-1:0] win_max;
  logic [WORD_SIZE-1:0] pool_val;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign transfer = out_valid_q && bus.out_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign lb_idx   = LB_AW'(col_q >> 1);
  assign lb_rd    = line_buf[lb_idx];
  assign pair_max = (bus.in_pixel > pmax_q) ? bus.in_pixel : pmax_q;
  assign win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;

`ifdef MAXPOOL_BINARIZE_EN
  assign pool_val = (win_max >= THRESH_W) ? '1 : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH_W;
  assign pool_val      = win_max;
`endif

  // Even col seeds pmax, odd col of an even row stores the pair, odd col of an odd row emits.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pmax_d      = pmax_q;
    out_pixel_d = out_pixel_q;
    out_valid_d = out_valid_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    lb_we       = 1'b0;

    if (transfer) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (!col_q[0]) begin
        pmax_d = bus.in_pixel;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_pixel_d = pool_val;
        out_valid_d = 1'b1;
        out_eol_d   = col_last;
        out_eof_d   = col_last && row_last;
      end

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pmax_q      <= '0;
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pmax_q      <= pmax_d;
      out_pixel_q <= out_pixel_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
    end
  end

  // No reset: every entry is rewritten on an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf[lb_idx] <= pair_max;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_eof   = out_eof_q;
endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Streaming 2x2 max-pooling stage with stride 2. Sits directly downstream of the Laplacian edge-detection convolution stage and consumes its clamped 8-bit output pixel stream.
- Halves the frame in each dimension, e.g. 540x540 in becomes 270x270 out, before the next CNN layer.
- Uses a valid/ready handshake on both sides and a half-row line buffer of partial maxima.

Parameters:
- WORD_SIZE, 8, pixel width in bits; unsigned.
- ROW_SIZE, 540, input pixels per row; must be even and >= 2.
- COL_SIZE, 540, input rows per frame; must be even and >= 2.
- THRESHOLD, 64, binarization threshold; used only with MAXPOOL_BINARIZE_EN.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  in_pixel is valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_pixel  input  WORD_SIZE  input pixel, raster order.
- out_valid  output  1  out_pixel is valid.
- out_ready  input  1  downstream accepts out_pixel.
- out_pixel  output  WORD_SIZE  pooled pixel.
- out_eol  output  1  out_pixel is the last pooled pixel of its output row.
- out_eof  output  1  out_pixel is the last pooled pixel of the frame.

Behaviour:
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready); no combinational path from in_valid to out_valid.
- Counters:
  - col: 0..ROW_SIZE-1. row: 0..COL_SIZE-1. Both advance only on an input accept.
  - col wraps to 0 at ROW_SIZE-1 and row increments.
  - row wraps to 0 at COL_SIZE-1; the next accept starts a new frame with no idle cycle required.
- Datapath (all compares unsigned):
  - pmax register: on accept with even col, pmax <= in_pixel.
  - Even row, odd col: line_buf[col>>1] <= max(pmax, in_pixel). Line buffer depth is ROW_SIZE/2 words.
  - Odd row, odd col: out_pixel <= max(line_buf[col>>1], pmax, in_pixel).
    - out_valid <= 1.
    - out_eol <= (col == ROW_SIZE-1).
    - out_eof <= (col == ROW_SIZE-1 && row == COL_SIZE-1).
- Latency: out_valid rises on the clock edge that accepts the 4th pixel of a window; output is registered, with one output slot.
- Output holding: while out_valid && !out_ready, out_pixel, out_eol and out_eof hold stable and in_ready = 0.
- out_valid clears on a transfer unless the same cycle accepts a window-completing pixel; in that case the new result loads back-to-back with out_valid kept at 1.
- Simultaneous events: back-to-back transfer plus load is the only overlap case. Even-row pixels never generate output and are still gated by in_ready.
- Reset (rst = 0, any time including mid-frame):
  - Values: col = 0, row = 0, pmax = 0, out_valid = 0, out_pixel = 0, out_eol = 0, out_eof = 0.
  - Partial frame is discarded. Line buffer is not cleared; it is fully rewritten on the next even row before being read.
  - in_ready = 1 during and after reset.
- Not checked: ROW_SIZE/COL_SIZE oddness; the result is undefined for odd values.

Optional Feature:
- Macro: MAXPOOL_BINARIZE_EN.
- Defined: the pooled value m is replaced by all-ones (255 for WORD_SIZE = 8) if m >= THRESHOLD, else 0. This is applied at the output-register load, so latency is unchanged.
- Undefined: out_pixel = m unmodified, and THRESHOLD is ignored.

Test Plan:
- ROW_SIZE=4, COL_SIZE=4, continuous input 1..16, out_ready=1 -> outputs 6, 8 (eol), 14, 16 (eol, eof); each out_valid appears 1 cycle after pixels 6, 8, 14, 16 are accepted.
- Same stream with out_ready=0 for 5 cycles after the first output -> out_pixel holds 6, in_ready=0 for those cycles, no pixel lost; sequence still 6, 8, 14, 16.
- Max-position check with rows {200,0,0,0}, {0,0,0,0}, {0,0,0,0}, {0,0,0,77} -> outputs 200, 0, 0, 77; also all-255 frame -> all outputs 255.
- in_valid toggled randomly (about 50% duty), two frames back-to-back -> identical output sequence per frame; out_eof asserted exactly once per frame.
- Reset (rst=0 for 1 cycle) after 6 pixels accepted -> out_valid=0 on the next cycle; a fresh 1..16 frame then yields 6, 8, 14, 16.
- With MAXPOOL_BINARIZE_EN and THRESHOLD=64: windows with max 63 and 64 -> out_pixel 0 and 255 respectively.
